alu_writeback_stage: RTL and testbench

- Execute-to-writeback stage directly downstream of the 16-bit saturating adder/subtractor.
- Captures each adder result (sum, overflow) with its destination register tag into a 2-entry skid buffer, then hands it to the register-file writer over a valid/ready handshake.
- Derives the Z/V/N condition codes and maintains the 3-bit architectural flag register consumed by branch logic.
- Counts retired ALU ops.

---
 rtl/alu_writeback_stage.sv | 118 +++++++++++
 tb/tb_alu_writeback_stage.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage
//
// Execute-to-writeback stage that sits directly behind the 16-bit saturating
// adder/subtractor. Each accepted adder result, together with its destination
// register tag, goes into a two-entry skid buffer (main + skid). From there it
// is handed to the register-file writer over a valid/ready handshake. The
// stage also keeps the architectural Z/V/N flag register and counts the
// accepted ALU ops.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   in_valid/in_ready  upstream handshake; in_ready depends only on state and rst
//   in_sum, in_overflow, in_rd, in_flag_we   adder result and its attributes
//   flush              drops every buffered result and the input of this cycle
//   out_valid/out_ready   downstream handshake toward the register-file writer
//   out_data, out_rd   result and destination tag (the main entry)
//   flags              [2]=Z, [1]=V, [0]=N, updated when a result is accepted
//   op_count           accepted-result counter, wraps around
module alu_writeback_stage #(
  parameter int WIDTH = 16,
  parameter int RD_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_overflow,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             in_flag_we,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [RD_W-1:0]  out_rd,
  output logic [2:0]       flags,
  output logic [CNT_W-1:0] op_count
);

  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic [RD_W-1:0]  main_rd;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic [RD_W-1:0]  skid_rd;
  logic             accept;
  logic             pop;

  // in_ready is taken from the skid register only, so there is no
  // combinational path from out_ready back to the upstream adder.
  assign in_ready  = !rst && !skid_valid;
  assign accept    = in_valid && in_ready && !flush;
  assign pop       = main_valid && out_ready;

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_rd    = main_rd;

  // Skid buffer. The main entry always holds the oldest result, so FIFO order
  // falls out of the moves below: a pop pulls the skid entry forward, and a
  // new result lands in main only if main is (or is becoming) empty.
  // Flush clears the valid bits and leaves the stale payload in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_rd    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_rd    <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (pop) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        main_rd    <= skid_rd;
        skid_valid <= accept;
        if (accept) begin
          skid_data <= in_sum;
          skid_rd   <= in_rd;
        end
      end else if (accept) begin
        main_data <= in_sum;
        main_rd   <= in_rd;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!main_valid) begin
        main_valid <= 1'b1;
        main_data  <= in_sum;
        main_rd    <= in_rd;
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= in_sum;
        skid_rd    <= in_rd;
      end
    end
  end

  // Flags and the op counter are committed at accept time, in program order,
  // independent of when the result eventually leaves the buffer. A flushed
  // input never reaches accept, so it changes neither of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags    <= 3'b000;
      op_count <= '0;
    end else if (accept) begin
      op_count <= op_count + CNT_W'(1);
      if (in_flag_we) begin
        flags <= {(in_sum == '0), in_overflow, in_sum[WIDTH-1]};
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb_alu_writeback_stage
//
// Directed scenarios plus a randomized phase for alu_writeback_stage. A
// queue-based model (FIFO of capacity two, flag register, counter) predicts
// every output; the directed steps additionally compare against hand-derived
// constants.
module tb_alu_writeback_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_sum;
  logic        in_overflow;
  logic [3:0]  in_rd;
  logic        in_flag_we;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_rd;
  logic [2:0]  flags;
  logic [15:0] op_count;

  int checks;
  int failures;

  // Reference model state
  logic [19:0] mq[$];
  logic [2:0]  mFlags;
  logic [15:0] mCount;
  logic        mZeroData;

  alu_writeback_stage #(.WIDTH(16), .RD_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_overflow(in_overflow), .in_rd(in_rd),
    .in_flag_we(in_flag_we), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .flags(flags), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with the model's prediction for the current cycle
  task automatic checkModel();
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, (!rst && mq.size() < 2)});
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
    checkOutput("flags", {29'd0, flags}, {29'd0, mFlags});
    checkOutput("op_count", {16'd0, op_count}, {16'd0, mCount});
    if (mq.size() > 0) begin
      checkOutput("out_data", {16'd0, out_data}, {16'd0, mq[0][19:4]});
      checkOutput("out_rd", {28'd0, out_rd}, {28'd0, mq[0][3:0]});
    end else if (mZeroData) begin
      checkOutput("out_data_rst", {16'd0, out_data}, 32'd0);
      checkOutput("out_rd_rst", {28'd0, out_rd}, 32'd0);
    end
  endtask

  // Advance the model by one clock edge using the behavioural rules:
  // the buffer is a two-deep FIFO; flags/counter change on accept only.
  task automatic modelEdge();
    logic acc;
    logic pp;
    if (rst) begin
      mq.delete();
      mFlags    = 3'b000;
      mCount    = 16'd0;
      mZeroData = 1'b1;
    end else if (flush) begin
      mq.delete();
    end else begin
      acc = in_valid && (mq.size() < 2);
      pp  = (mq.size() > 0) && out_ready;
      if (pp) void'(mq.pop_front());
      if (acc) begin
        mq.push_back({in_sum, in_rd});
        mCount    = mCount + 16'd1;
        mZeroData = 1'b0;
        if (in_flag_we)
          mFlags = {(in_sum == 16'd0), in_overflow, in_sum[15]};
      end
    end
  endtask

  // Drive one cycle of inputs (called at a negedge), optionally check the
  // outputs, then advance through the rising edge to the next negedge.
  task automatic applyStimulus(input logic r, input logic v, input logic [15:0] sum,
                               input logic ovf, input logic [3:0] rd, input logic fwe,
                               input logic fl, input logic ordy, input logic chk);
    rst         = r;
    in_valid    = v;
    in_sum      = sum;
    in_overflow = ovf;
    in_rd       = rd;
    in_flag_we  = fwe;
    flush       = fl;
    out_ready   = ordy;
    #1;
    if (chk) checkModel();
    modelEdge();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] rs;
    checks    = 0;
    failures  = 0;
    mFlags    = 3'b000;
    mCount    = 16'd0;
    mZeroData = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_overflow = 1'b0; in_rd = '0;
    in_flag_we = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);

    // Reset
    applyStimulus(1, 0, 16'h0, 0, 4'd0, 0, 0, 0, 0);
    applyStimulus(1, 1, 16'h55, 0, 4'd1, 1, 0, 1, 1);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_flags", {29'd0, flags}, 32'd0);
    checkOutput("rst_count", {16'd0, op_count}, 32'd0);

    // Single op with zero sum
    applyStimulus(0, 1, 16'h0000, 0, 4'd3, 1, 0, 1, 1);
    checkOutput("single_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("single_data", {16'd0, out_data}, 32'd0);
    checkOutput("single_rd", {28'd0, out_rd}, 32'd3);
    checkOutput("single_flags", {29'd0, flags}, 32'b100);
    checkOutput("single_count", {16'd0, op_count}, 32'd1);
    applyStimulus(0, 0, 16'h0, 0, 4'd0, 0, 0, 1, 1);

    // Backpressure fills both entries
    applyStimulus(0, 1, 16'h1234, 0, 4'd1, 0, 0, 0, 1);
    applyStimulus(0, 1, 16'h8000, 0, 4'd2, 0, 0, 0, 1);
    checkOutput("bp_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("bp_hold", {16'd0, out_data}, 32'h1234);
    applyStimulus(0, 0, 16'h0, 0, 4'd0, 0, 0, 0, 1);
    checkOutput("bp_hold2", {16'd0, out_data}, 32'h1234);
    applyStimulus(0, 0, 16'h0, 0, 4'd0, 0, 0, 1, 1);
    checkOutput("bp_pop2_data", {16'd0, out_data}, 32'h8000);
    checkOutput("bp_pop2_rd", {28'd0, out_rd}, 32'd2);
    checkOutput("bp_ready_back", {31'd0, in_ready}, 32'd1);
    applyStimulus(0, 0, 16'h0, 0, 4'd0, 0, 0, 1, 1);
    checkOutput("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flag semantics
    applyStimulus(0, 1, 16'h7FFF, 1, 4'd4, 1, 0, 1, 1);
    checkOutput("flags_7fff", {29'd0, flags}, 32'b010);
    applyStimulus(0, 1, 16'h8000, 1, 4'd5, 1, 0, 1, 1);
    checkOutput("flags_8000", {29'd0, flags}, 32'b011);
    applyStimulus(0, 1, 16'h0000, 0, 4'd6, 0, 0, 1, 1);
    checkOutput("flags_nowe", {29'd0, flags}, 32'b011);
    applyStimulus(0, 0, 16'h0, 0, 4'd0, 0, 0, 1, 1);

    // Pop and offered input together while both entries are full
    applyStimulus(0, 1, 16'hAAAA, 0, 4'd7, 0, 0, 0, 1);
    applyStimulus(0, 1, 16'hBBBB, 0, 4'd8, 0, 0, 0, 1);
    rs = op_count;
    applyStimulus(0, 1, 16'hCCCC, 0, 4'd9, 0, 0, 1, 1);
    checkOutput("sim_data", {16'd0, out_data}, 32'hBBBB);
    checkOutput("sim_count", {16'd0, op_count}, {16'd0, rs});
    applyStimulus(0, 0, 16'h0, 0, 4'd0, 0, 0, 1, 1);
    checkOutput("sim_drained", {31'd0, out_valid}, 32'd0);

    // Flush with two buffered entries and an offered input
    applyStimulus(0, 1, 16'h1111, 1, 4'd1, 1, 0, 0, 1);
    applyStimulus(0, 1, 16'h2222, 0, 4'd2, 1, 0, 0, 1);
    rs = op_count;
    applyStimulus(0, 1, 16'h0000, 0, 4'd3, 1, 1, 0, 1);
    checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("flush_flags", {29'd0, flags}, 32'b000);
    checkOutput("flush_count", {16'd0, op_count}, {16'd0, rs});

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       rs = 16'h0000;
        1:       rs = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
        default: rs = 16'($urandom);
      endcase
      applyStimulus(0, $urandom_range(0, 3) != 0, rs, 1'($urandom),
                    4'($urandom), 1'($urandom), $urandom_range(0, 15) == 0,
                    $urandom_range(0, 2) != 0, 1);
    end

    // Counter wrap
    applyStimulus(1, 0, 16'h0, 0, 4'd0, 0, 0, 0, 1);
    for (int i = 0; i < 65535; i++)
      applyStimulus(0, 1, 16'(i), 0, 4'(i), 0, 0, 1, 0);
    checkOutput("wrap_max", {16'd0, op_count}, 32'd65535);
    applyStimulus(0, 1, 16'hFFFF, 0, 4'd15, 1, 0, 1, 1);
    checkOutput("wrap_zero", {16'd0, op_count}, 32'd0);
    checkOutput("wrap_flags", {29'd0, flags}, 32'b001);

    // Reset while a result is waiting
    applyStimulus(0, 1, 16'h4321, 1, 4'd2, 1, 0, 0, 1);
    checkOutput("midrst_pre", {31'd0, out_valid}, 32'd1);
    applyStimulus(1, 1, 16'h0, 0, 4'd0, 1, 0, 1, 1);
    checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_flags", {29'd0, flags}, 32'd0);
    checkOutput("midrst_count", {16'd0, op_count}, 32'd0);
    applyStimulus(0, 0, 16'h0, 0, 4'd0, 0, 0, 1, 1);
    checkOutput("midrst_ready", {31'd0, in_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
